// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrantI = 2'd1,
        StGrantD = 2'd2
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

endpackage

// File: rtl/ram_arb_watchdog.sv
// Per-access watchdog: counts strobed cycles without a slave response and
// fires a one-cycle timeout when the limit is reached.
module ram_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic stb_i,
    input  logic ack_i,
    input  logic err_i,
    input  logic clear_i,
    output logic timeout_o
);

    localparam int unsigned CntBits  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntWidth = (CntBits > 8) ? CntBits : 8;

    logic [CntWidth-1:0] count_q, count_d;

    always_comb begin
        // A response landing on the limit cycle wins over the timeout.
        timeout_o = stb_i & ~ack_i & ~err_i & (count_q == CntWidth'(TIMEOUT_CYCLES));
        count_d   = count_q + CntWidth'(1);
        if (clear_i || !stb_i || ack_i || err_i || timeout_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin Wishbone arbiter sharing one RAM controller between the
// instruction-fetch and load/store masters, with cycle locking and a watchdog.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    i_cyc_i,
    input  logic                    i_stb_i,
    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    output logic [DATA_WIDTH-1:0]   i_data_o,
    output logic                    i_ack_o,
    output logic                    i_err_o,
    input  logic                    d_cyc_i,
    input  logic                    d_stb_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_sel_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_data_i,
    output logic [DATA_WIDTH-1:0]   d_data_o,
    output logic                    d_ack_o,
    output logic                    d_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              grant_o
);

    arb_state_t state_q, state_d;
    logic       last_i_q, last_i_d;
    logic       req_i, req_d;
    logic       own_i, own_d;
    logic       own_cyc, own_stb;
    logic       release_own;
    logic       timeout;

    assign req_i       = i_cyc_i & i_stb_i;
    assign req_d       = d_cyc_i & d_stb_i;
    assign own_i       = (state_q == StGrantI);
    assign own_d       = (state_q == StGrantD);
    assign own_cyc     = (own_i & i_cyc_i) | (own_d & d_cyc_i);
    assign own_stb     = (own_i & i_cyc_i & i_stb_i) | (own_d & d_cyc_i & d_stb_i);
    assign release_own = (own_i | own_d) & ~own_cyc;

    ram_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .stb_i    (own_stb),
        .ack_i    (s_ack_i),
        .err_i    (s_err_i),
        .clear_i  (release_own),
        .timeout_o(timeout)
    );

    always_comb begin
        state_d  = state_q;
        last_i_d = last_i_q;
        unique case (state_q)
            StIdle: begin
                // On a tie, serve whichever master was not granted most recently.
                if (req_i && (!req_d || !last_i_q)) begin
                    state_d  = StGrantI;
                    last_i_d = 1'b1;
                end else if (req_d) begin
                    state_d  = StGrantD;
                    last_i_d = 1'b0;
                end
            end
            StGrantI: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (!i_cyc_i) begin
                    if (req_d) begin
                        state_d  = StGrantD;
                        last_i_d = 1'b0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StGrantD: begin
                if (timeout) begin
                    state_d = StIdle;
                end else if (!d_cyc_i) begin
                    if (req_i) begin
                        state_d  = StGrantI;
                        last_i_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_cyc_o  = own_cyc & ~timeout;
        s_stb_o  = own_stb & ~timeout;
        s_we_o   = own_d & d_we_i;
        s_sel_o  = '0;
        s_addr_o = '0;
        s_data_o = '0;
        grant_o  = GRANT_NONE;
        if (own_i) begin
            s_sel_o  = '1;
            s_addr_o = i_addr_i;
            grant_o  = GRANT_I;
        end else if (own_d) begin
            s_sel_o  = d_sel_i;
            s_addr_o = d_addr_i;
            s_data_o = d_data_i;
            grant_o  = GRANT_D;
        end
        i_ack_o  = own_i & s_ack_i;
        i_err_o  = own_i & (s_err_i | timeout);
        d_ack_o  = own_d & s_ack_i;
        d_err_o  = own_d & (s_err_i | timeout);
        i_data_o = s_data_i;
        d_data_o = s_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            last_i_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// master/slave traffic, all compared cycle by cycle against a behavioural model.
module tb_ram_arbiter;

    localparam int T = 8;

    logic        clk, rst_n;
    logic        i_cyc, i_stb;
    logic [31:0] i_addr, i_data_o;
    logic        i_ack_o, i_err_o;
    logic        d_cyc, d_stb, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata, d_data_o;
    logic        d_ack_o, d_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_rdata;
    logic        s_ack, s_err;
    logic [1:0]  grant_o;

    ram_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .i_cyc_i (i_cyc),
        .i_stb_i (i_stb),
        .i_addr_i(i_addr),
        .i_data_o(i_data_o),
        .i_ack_o (i_ack_o),
        .i_err_o (i_err_o),
        .d_cyc_i (d_cyc),
        .d_stb_i (d_stb),
        .d_we_i  (d_we),
        .d_sel_i (d_sel),
        .d_addr_i(d_addr),
        .d_data_i(d_wdata),
        .d_data_o(d_data_o),
        .d_ack_o (d_ack_o),
        .d_err_o (d_err_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_we_o  (s_we_o),
        .s_sel_o (s_sel_o),
        .s_addr_o(s_addr_o),
        .s_data_o(s_data_o),
        .s_data_i(s_rdata),
        .s_ack_i (s_ack),
        .s_err_i (s_err),
        .grant_o (grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Model: owner 0 = none, 1 = instruction, 2 = data; last_i = 1 if instruction served last.
    int   m_owner, m_wait;
    bit   m_last_i;
    int   n_owner, n_wait;
    bit   n_last_i;
    bit   e_i_ack, e_i_err, e_d_ack, e_d_err;

    task automatic model_reset();
        m_owner  = 0;
        m_last_i = 1'b1;
        m_wait   = 0;
    endtask

    task automatic model_step();
        bit          ri, rd, o_cyc, o_stb, hung;
        logic [73:0] e_slave;
        logic [1:0]  e_grant;
        ri      = i_cyc && i_stb;
        rd      = d_cyc && d_stb;
        o_cyc   = (m_owner == 1) ? i_cyc : (m_owner == 2) ? d_cyc : 1'b0;
        o_stb   = o_cyc && ((m_owner == 1) ? i_stb : d_stb);
        hung    = o_stb && (m_wait == T) && !s_ack && !s_err;
        e_grant = 2'(m_owner);
        if (m_owner == 1)
            e_slave = {o_cyc && !hung, o_stb && !hung, 1'b0, 4'hF, i_addr, 32'h0};
        else if (m_owner == 2)
            e_slave = {o_cyc && !hung, o_stb && !hung, d_we, d_sel, d_addr, d_wdata};
        else
            e_slave = '0;
        e_i_ack = (m_owner == 1) && s_ack;
        e_i_err = (m_owner == 1) && (s_err || hung);
        e_d_ack = (m_owner == 2) && s_ack;
        e_d_err = (m_owner == 2) && (s_err || hung);

        check_eq("grant", 128'(grant_o), 128'(e_grant));
        check_eq("slave_bus", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o}),
                 128'(e_slave));
        check_eq("i_resp", 128'({i_ack_o, i_err_o, i_data_o}), 128'({e_i_ack, e_i_err, s_rdata}));
        check_eq("d_resp", 128'({d_ack_o, d_err_o, d_data_o}), 128'({e_d_ack, e_d_err, s_rdata}));

        n_owner  = m_owner;
        n_last_i = m_last_i;
        if (m_owner == 0) begin
            if (ri && rd) n_owner = m_last_i ? 2 : 1;
            else if (ri) n_owner = 1;
            else if (rd) n_owner = 2;
        end else if (hung) begin
            n_owner = 0;
        end else if (!o_cyc) begin
            if (m_owner == 1) n_owner = rd ? 2 : 0;
            else              n_owner = ri ? 1 : 0;
        end
        if (n_owner != 0 && n_owner != m_owner) n_last_i = (n_owner == 1);
        n_wait = (o_stb && !s_ack && !s_err && !hung) ? m_wait + 1 : 0;
    endtask

    // Checks the current cycle at the falling edge, then advances to just past the next rise.
    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        m_owner  = n_owner;
        m_last_i = n_last_i;
        m_wait   = n_wait;
        #1;
    endtask

    task automatic drive_slave_random(input int ack_th);
        bit o_stb;
        o_stb   = (m_owner == 1 && i_cyc && i_stb) || (m_owner == 2 && d_cyc && d_stb);
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_rdata = $urandom;
        if (o_stb) begin
            int r;
            r = int'($urandom_range(15));
            if (r < ack_th) s_ack = 1'b1;
            else if (r == 15) s_err = 1'b1;
        end
    endtask

    task automatic drive_i_random();
        if (!i_cyc) begin
            if ($urandom_range(3) == 0) begin
                i_cyc = 1'b1; i_stb = 1'b1; i_addr = $urandom;
            end
        end else if (e_i_err) begin
            i_cyc = 1'b0; i_stb = 1'b0;
        end else if (e_i_ack) begin
            case ($urandom_range(2))
                0: begin i_cyc = 1'b0; i_stb = 1'b0; end
                1: i_addr = $urandom;
                default: i_stb = 1'b0;
            endcase
        end else if (!i_stb) begin
            if ($urandom_range(1) == 1) begin i_stb = 1'b1; i_addr = $urandom; end
        end else if ($urandom_range(31) == 0) begin
            i_cyc = 1'b0; i_stb = 1'b0;
        end
    endtask

    task automatic new_d_access();
        d_stb = 1'b1; d_we = 1'($urandom); d_sel = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
    endtask

    task automatic drive_d_random();
        if (!d_cyc) begin
            if ($urandom_range(3) == 0) begin d_cyc = 1'b1; new_d_access(); end
        end else if (e_d_err) begin
            d_cyc = 1'b0; d_stb = 1'b0;
        end else if (e_d_ack) begin
            case ($urandom_range(2))
                0: begin d_cyc = 1'b0; d_stb = 1'b0; end
                1: new_d_access();
                default: d_stb = 1'b0;
            endcase
        end else if (!d_stb) begin
            if ($urandom_range(1) == 1) new_d_access();
        end else if ($urandom_range(31) == 0) begin
            d_cyc = 1'b0; d_stb = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        {i_cyc, i_stb, d_cyc, d_stb, d_we, s_ack, s_err} = '0;
        i_addr = '0; d_sel = '0; d_addr = '0; d_wdata = '0;
        s_rdata = 32'hA5A5_5A5A;
        e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
        model_reset();
        #1;
        check_eq("rst_outs", 128'({s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_addr_o, s_data_o,
                 i_ack_o, i_err_o, d_ack_o, d_err_o, grant_o}), 128'(0));
        check_eq("rst_data", 128'({i_data_o, d_data_o}), 128'({32'hA5A5_5A5A, 32'hA5A5_5A5A}));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single instruction read, ack on the third strobed cycle.
        i_cyc = 1; i_stb = 1; i_addr = 32'h4000_0010;
        cycle();
        check_eq("rd_grant", 128'(grant_o), 128'(2'b01));
        check_eq("rd_stb", 128'(s_stb_o), 128'(1));
        cycle(); cycle();
        s_ack = 1; s_rdata = 32'hDEAD_BEEF; #1;
        check_eq("rd_ack", 128'({i_ack_o, i_data_o, d_ack_o}), 128'({1'b1, 32'hDEAD_BEEF, 1'b0}));
        cycle();
        s_ack = 0; i_cyc = 0; i_stb = 0;
        cycle();
        check_eq("rd_release", 128'(grant_o), 128'(2'b00));

        // Tie: data wins, then direct hand-off to instruction.
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1; d_we = 0; d_addr = 32'h4000_0200;
        cycle();
        check_eq("tie1_grant", 128'(grant_o), 128'(2'b10));
        s_ack = 1; cycle();
        s_ack = 0; d_cyc = 0; d_stb = 0; cycle();
        check_eq("handoff", 128'({grant_o, s_stb_o}), 128'({2'b01, 1'b1}));
        s_ack = 1; cycle();
        s_ack = 0; i_cyc = 0; i_stb = 0; cycle();
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        check_eq("tie2_grant", 128'(grant_o), 128'(2'b10));
        i_cyc = 0; i_stb = 0; s_ack = 1; cycle();
        s_ack = 0; d_cyc = 0; d_stb = 0; cycle();
        i_cyc = 1; i_stb = 1; d_cyc = 1; d_stb = 1;
        cycle();
        check_eq("tie3_grant", 128'(grant_o), 128'(2'b01));
        s_ack = 1; cycle();
        s_ack = 0; i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0; cycle();

        // Data write with partial selects; instruction stalls until data releases.
        d_cyc = 1; d_stb = 1; d_we = 1; d_sel = 4'b0011;
        d_addr = 32'h4000_0100; d_wdata = 32'h1234_5678;
        cycle();
        check_eq("wr_bus", 128'({grant_o, s_we_o, s_sel_o, s_addr_o, s_data_o}),
                 128'({2'b10, 1'b1, 4'b0011, 32'h4000_0100, 32'h1234_5678}));
        i_cyc = 1; i_stb = 1; i_addr = 32'h4000_0020;
        cycle();
        check_eq("wr_stall1", 128'(grant_o), 128'(2'b10));
        s_ack = 1; cycle();
        s_ack = 0; cycle();
        check_eq("wr_stall2", 128'(grant_o), 128'(2'b10));
        s_ack = 1; cycle();
        s_ack = 0; d_cyc = 0; d_stb = 0; d_we = 0; cycle();
        check_eq("wr_handoff", 128'(grant_o), 128'(2'b01));
        s_ack = 1; cycle();
        s_ack = 0; i_cyc = 0; i_stb = 0; cycle();

        // Watchdog: slave never answers.
        d_cyc = 1; d_stb = 1; d_addr = 32'h4000_0300;
        cycle();
        for (int k = 0; k < T; k++) begin
            check_eq("wd_early", 128'(d_err_o), 128'(0));
            cycle();
        end
        check_eq("wd_fire", 128'({d_err_o, s_cyc_o, s_stb_o}), 128'({1'b1, 1'b0, 1'b0}));
        cycle();
        d_cyc = 0; d_stb = 0; #1;
        check_eq("wd_idle", 128'(grant_o), 128'(2'b00));
        cycle();

        // Ack on the limit cycle beats the timeout.
        d_cyc = 1; d_stb = 1;
        cycle();
        for (int k = 0; k < T; k++) cycle();
        s_ack = 1; #1;
        check_eq("wd_ack_wins", 128'({d_ack_o, d_err_o, s_stb_o}), 128'({1'b1, 1'b0, 1'b1}));
        cycle();
        s_ack = 0; d_cyc = 0; d_stb = 0; cycle();
        check_eq("wd_ack_rel", 128'(grant_o), 128'(2'b00));

        // Reset in the middle of an instruction access.
        i_cyc = 1; i_stb = 1;
        cycle();
        check_eq("mid_grant", 128'({grant_o, s_stb_o}), 128'({2'b01, 1'b1}));
        cycle();
        rst_n = 0; #1;
        check_eq("mid_rst", 128'({s_cyc_o, s_stb_o, grant_o, i_ack_o, i_err_o, d_ack_o, d_err_o}),
                 128'(0));
        model_reset();
        #1; rst_n = 1;
        d_cyc = 1; d_stb = 1;
        cycle();
        check_eq("post_rst_tie", 128'(grant_o), 128'(2'b10));
        s_ack = 1; cycle();
        s_ack = 0; i_cyc = 0; i_stb = 0; d_cyc = 0; d_stb = 0; cycle();
        e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;

        // Random traffic: responsive slave, then a sluggish one that trips the watchdog.
        for (int c = 0; c < 1200; c++) begin
            drive_i_random();
            drive_d_random();
            drive_slave_random((c < 600) ? 6 : 1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master to one-slave Wishbone (classic, pipelined-free) arbiter that shares the single external RAM controller (SDRAM on ULX3S, PSRAM on Blue Whale) between the instruction-fetch port and the load/store data port of `risc_p`. It sits between the pipeline's memory-space front end and the RAM controller. It provides round-robin fairness, bus locking for the duration of a master's cycle, direct grant hand-off, and a per-access watchdog that converts a hung slave into a bus error.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, data bus width; `DATA_WIDTH/8` select bits.
- `TIMEOUT_CYCLES`, 255, cycles a strobed access may wait for ack/err before it is aborted; minimum 2.

Ports. One clock, `clk_i`. Reset `rst_n_i` is asynchronous and active-low.
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  asynchronous active-low reset
- `i_cyc_i`, `i_stb_i`  in  1  instruction master cycle/strobe (read-only)
- `i_addr_i`  in  ADDR_WIDTH  instruction fetch address
- `i_data_o`  out  DATA_WIDTH  read data
- `i_ack_o`, `i_err_o`  out  1  instruction master ack/error
- `d_cyc_i`, `d_stb_i`, `d_we_i`  in  1  data master cycle/strobe/write-enable
- `d_sel_i`  in  DATA_WIDTH/8  byte selects
- `d_addr_i`  in  ADDR_WIDTH  data address
- `d_data_i`  in  DATA_WIDTH  write data
- `d_data_o`  out  DATA_WIDTH  read data
- `d_ack_o`, `d_err_o`  out  1  data master ack/error
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1  to RAM controller
- `s_sel_o`  out  DATA_WIDTH/8
- `s_addr_o`  out  ADDR_WIDTH
- `s_data_o`  out  DATA_WIDTH
- `s_data_i`  in  DATA_WIDTH
- `s_ack_i`, `s_err_i`  in  1  from RAM controller
- `grant_o`  out  2  current owner: 00 none, 01 instruction, 10 data (status/perf counters)

## Operation
- States: `IDLE`, `GRANT_I`, `GRANT_D`. The registered `last_i` bit records the most recently granted master.
- `IDLE`: a request is `x_cyc_i & x_stb_i`. With one request, grant that master. With both, grant the master not equal to `last_i`. Reset value of `last_i` = 1, so data wins the first tie.
- `GRANT_x`: the owner's cyc/stb/we/sel/addr/data are muxed combinationally to `s_*`. For the instruction master, `s_we_o` = 0 and `s_sel_o` = all ones. `s_ack_i`/`s_err_i`/`s_data_i` are routed to the owner only. The non-owner's ack/err are held at 0, and its data output equals `s_data_i`.
- Lock: the grant is held while the owner's `cyc_i` = 1, including multiple strobes in one cycle.
- Release: when the owner's `cyc_i` = 0:
  - If the other master is requesting, go directly to its grant (no IDLE cycle).
  - Otherwise go to `IDLE`.
  - Set `last_i` accordingly.
- Watchdog: an 8+ bit counter.
  - Cleared on ack, err, release, or while `s_stb_o` = 0.
  - Increments each cycle `s_stb_o` = 1 with no ack/err.
  - When it reaches `TIMEOUT_CYCLES`: assert the owner's `err_o` for one cycle, force `s_cyc_o`/`s_stb_o` = 0 that cycle, clear the counter, and go to `IDLE`. The owner must drop `cyc_i`. A re-request is arbitrated normally.
- `s_err_i` passes through unchanged as the owner's `err_o`; it does not change the grant.
- An owner dropping `cyc_i` before ack abandons the access; the slave sees `s_cyc_o` fall the same cycle.

## Timing
- Reset (async assert): state `IDLE`, `grant_o` = 00, `last_i` = 1, counter = 0. All `s_*` outputs, ack and err outputs = 0. Data outputs follow `s_data_i`.
- Arbitration latency is 1 cycle: a request in cycle N from `IDLE` gives `s_stb_o` = 1 in cycle N+1.
- Ack/err/read-data return is combinational, with 0 added latency.
- Hand-off: owner drops cyc in cycle N and the other master is pending, so the other master's `s_stb_o` = 1 in cycle N+1.
- Timeout: strobe first asserted in cycle N with no response gives `err_o` in cycle N+`TIMEOUT_CYCLES`.
- Ack and timeout in the same cycle: ack wins, and no err is issued.
- Reset asserted mid-access: outputs drop asynchronously and the in-flight access is lost. Masters must restart.

## Structure
- Shared package `ram_arb_pkg`: `arb_state_t` enum (`IDLE`, `GRANT_I`, `GRANT_D`) and `GRANT_NONE`/`GRANT_I`/`GRANT_D` 2-bit constants. `memory_map.svh` is unchanged.
- One sub-module, `ram_arb_watchdog` (counter + timeout pulse, parameter `TIMEOUT_CYCLES`). The FSM and muxes stay in `ram_arbiter`.

## Test plan
- Single instruction read, addr 0x4000_0010, slave acks after 3 cycles with 0xDEAD_BEEF -> `i_ack_o` 1 cycle, `i_data_o` = 0xDEAD_BEEF, `grant_o` 01 then 00, `d_ack_o` never set.
- Both request in the same cycle after reset -> data granted first. After release the instruction master is granted with no idle cycle. The next tie goes to data again only if instruction was last served.
- Data write with `d_sel_i` = 0011 at 0x4000_0100, data 0x1234_5678 -> slave sees `s_we_o` = 1, sel 0011, addr and data unchanged. During the write, an instruction request stays stalled until `d_cyc_i` falls.
- `TIMEOUT_CYCLES` = 8, slave never acks -> `d_err_o` pulses exactly 8 cycles after the first `s_stb_o`, `s_cyc_o` = 0 that cycle, state returns to `IDLE`.
- Ack arrives in the same cycle the counter reaches `TIMEOUT_CYCLES` -> ack delivered, no err.
- `rst_n_i` pulled low mid-access -> all outputs 0 immediately. After release the first tie is granted to data.
